arm_mc_control_unit: RTL and testbench

Control unit for the multi-cycle ARM core. It replaces the single-cycle controller with a registered main FSM, and it sequences one instruction over several cycles through a shared memory port and a shared ALU. It adds features the single-cycle controller lacks: a memory-ready handshake with wait states, early retirement of condition-failed instructions, and a parametrised ALU-control width that enables EOR. It sits beside the multi-cycle datapath inside the core top level.

---
 rtl/arm_mc_control_unit_pkg.sv | 60 ++++++
 rtl/arm_mc_control_unit_if.sv | 34 +++
 rtl/arm_mc_control_unit_cond_check.sv | 34 +++
 rtl/arm_mc_control_unit.sv | 147 ++++++++++++++
 tb/tb_arm_mc_control_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle ARM control unit: FSM states,
// ALUControl codes, data-processing commands, condition codes and mux selects.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RM     = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

endpackage

// File: rtl/arm_mc_control_unit_if.sv
// Control bundle between the multi-cycle datapath (master) and the
// control unit (slave).
interface arm_mc_control_unit_if #(
  parameter int ALU_CTRL_W = 2
);
  logic [31:0]           Instr;
  logic [3:0]            ALUFlags;
  logic                  MemReady;
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  MemWrite;
  logic                  IRWrite;
  logic                  RegWrite;
  logic [1:0]            ResultSrc;
  logic                  ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ImmSrc;
  logic [1:0]            RegSrc;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic [3:0]            State;
  logic                  Undef;

  modport master (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State, Undef
  );

  modport slave (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State, Undef
  );
endinterface

// File: rtl/arm_mc_control_unit_cond_check.sv
// Condition evaluation: instruction Cond field against registered NZCV.
module arm_cond_check
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  // Standard ARM condition table; 1111 never executes.
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/arm_mc_control_unit.sv
// Multi-cycle ARM control unit: main FSM, ALU decoder, flag register and
// condition check. Outputs are decoded from the registered state; write
// enables are held low while RST is asserted.
module arm_mc_control_unit
  import arm_mc_pkg::*;
#(
  parameter int ALU_CTRL_W  = 2,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic                  CLK,
  input logic                  RST,
  arm_mc_control_unit_if.slave ctrl
);
  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_rdy, cond_ex;
  logic [2:0] dec_alu, alu_sel;
  logic       dec_nowrite, dec_flag_ok, dec_arith, flag_wr;
  logic       pc_wr, ir_wr, reg_wr, mem_wr;
  logic       unused_ok;

  assign cond    = ctrl.Instr[31:28];
  assign op      = ctrl.Instr[27:26];
  assign funct   = ctrl.Instr[25:20];
  assign rd      = ctrl.Instr[15:12];
  assign cmd     = funct[4:1];
  assign mem_rdy = MEM_WAIT_EN ? ctrl.MemReady : 1'b1;
  assign unused_ok = ^{ctrl.Instr[19:16], ctrl.Instr[11:0]};

  arm_cond_check u_cond (
    .cond_i    (cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  // ALU decoder: unsupported commands compute ADD but write nothing.
  always_comb begin
    dec_alu     = ALU_ADD;
    dec_nowrite = 1'b1;
    dec_flag_ok = 1'b0;
    dec_arith   = 1'b0;
    case (cmd)
      CMD_ADD: begin dec_alu = ALU_ADD; dec_nowrite = 1'b0; dec_flag_ok = 1'b1; dec_arith = 1'b1; end
      CMD_SUB: begin dec_alu = ALU_SUB; dec_nowrite = 1'b0; dec_flag_ok = 1'b1; dec_arith = 1'b1; end
      CMD_AND: begin dec_alu = ALU_AND; dec_nowrite = 1'b0; dec_flag_ok = 1'b1; end
      CMD_ORR: begin dec_alu = ALU_ORR; dec_nowrite = 1'b0; dec_flag_ok = 1'b1; end
      CMD_CMP: begin dec_alu = ALU_SUB; dec_flag_ok = 1'b1; dec_arith = 1'b1; end
      CMD_EOR: begin
        if (ALU_CTRL_W >= 3) begin
          dec_alu = ALU_EOR; dec_nowrite = 1'b0; dec_flag_ok = 1'b1;
        end
      end
      default: ;
    endcase
    flag_wr = dec_flag_ok & (funct[0] | (cmd == CMD_CMP));
  end

  // Next state and next flags; flags only move on leaving an EXEC state.
  always_comb begin
    state_d = S_FETCH;
    flags_d = flags_q;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!cond_ex || op == OP_UNDEF) state_d = S_FETCH;
        else if (op == OP_MEM)          state_d = S_MEMADR;
        else if (op == OP_BR)           state_d = S_BRANCH;
        else if (funct[5])              state_d = S_EXECI;
        else                            state_d = S_EXECR;
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXECR, S_EXECI: begin
        state_d = S_ALUWB;
        if (flag_wr) begin
          flags_d[3:2] = ctrl.ALUFlags[3:2];
          if (dec_arith) flags_d[1:0] = ctrl.ALUFlags[1:0];
        end
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // State and flag registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Per-state datapath controls.
  always_comb begin
    pc_wr          = 1'b0;
    ir_wr          = 1'b0;
    reg_wr         = 1'b0;
    mem_wr         = 1'b0;
    ctrl.AdrSrc    = 1'b0;
    ctrl.ResultSrc = RES_ALUOUT;
    ctrl.ALUSrcA   = 1'b0;
    ctrl.ALUSrcB   = SRCB_RM;
    ctrl.Undef     = 1'b0;
    alu_sel        = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ctrl.ALUSrcA = 1'b1; ctrl.ALUSrcB = SRCB_FOUR; ctrl.ResultSrc = RES_ALURESULT;
        ir_wr = mem_rdy; pc_wr = mem_rdy;
      end
      S_DECODE: begin
        ctrl.ALUSrcA = 1'b1; ctrl.ALUSrcB = SRCB_FOUR; ctrl.ResultSrc = RES_ALURESULT;
        ctrl.Undef = (op == OP_UNDEF);
      end
      S_MEMADR: ctrl.ALUSrcB = SRCB_EXTIMM;
      S_MEMRD:  ctrl.AdrSrc = 1'b1;
      S_MEMWB: begin
        ctrl.ResultSrc = RES_DATA; reg_wr = 1'b1; pc_wr = (rd == 4'hF);
      end
      S_MEMWR: begin ctrl.AdrSrc = 1'b1; mem_wr = 1'b1; end
      S_EXECR: alu_sel = dec_alu;
      S_EXECI: begin ctrl.ALUSrcB = SRCB_EXTIMM; alu_sel = dec_alu; end
      S_ALUWB: begin
        reg_wr = ~dec_nowrite; pc_wr = ~dec_nowrite & (rd == 4'hF);
      end
      S_BRANCH: begin
        ctrl.ALUSrcB = SRCB_EXTIMM; ctrl.ResultSrc = RES_ALURESULT; pc_wr = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl.PCWrite    = pc_wr  & ~RST;
  assign ctrl.IRWrite    = ir_wr  & ~RST;
  assign ctrl.RegWrite   = reg_wr & ~RST;
  assign ctrl.MemWrite   = mem_wr & ~RST;
  assign ctrl.ALUControl = ALU_CTRL_W'(alu_sel);
  assign ctrl.ImmSrc     = op;
  assign ctrl.RegSrc     = {op == OP_MEM, op == OP_BR};
  assign ctrl.State      = state_q;
endmodule

// File: tb/tb_arm_mc_control_unit.sv
// Bench for arm_mc_control_unit: two instances (ALU_CTRL_W=2 and 3) share
// one stimulus. Directed table, reset-in-MEMWR sequence, then random
// instructions checked cycle by cycle against a phase-level reference model.
module tb_arm_mc_control_unit;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] instr_v;
  logic [3:0]  alufl_v;
  logic        memrdy_v;
  int          tests = 0;
  int          fails = 0;

  always #5 CLK = ~CLK;

  arm_mc_control_unit_if #(.ALU_CTRL_W(2)) bus2 ();
  arm_mc_control_unit_if #(.ALU_CTRL_W(3)) bus3 ();

  assign bus2.Instr = instr_v;  assign bus3.Instr = instr_v;
  assign bus2.ALUFlags = alufl_v; assign bus3.ALUFlags = alufl_v;
  assign bus2.MemReady = memrdy_v; assign bus3.MemReady = memrdy_v;

  arm_mc_control_unit #(.ALU_CTRL_W(2), .MEM_WAIT_EN(1'b1)) dut2 (.CLK(CLK), .RST(RST), .ctrl(bus2.slave));
  arm_mc_control_unit #(.ALU_CTRL_W(3), .MEM_WAIT_EN(1'b1)) dut3 (.CLK(CLK), .RST(RST), .ctrl(bus3.slave));

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] alu;
    logic       und;
    logic [1:0] imm, rsrc;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  fl;
    int          mwait;
    logic [39:0] seq;
    int          ncyc, rw3, rw2, mw, pcw;
    logic [2:0]  alu3, alu2;
    int          und;
  } vec_t;

  exp_t       e2q[$], e3q[$];
  bit         mrq[$];
  logic [3:0] mflags;
  vec_t       tbl[18];

  function automatic exp_t obs3();
    return {bus3.State, bus3.PCWrite, bus3.AdrSrc, bus3.MemWrite, bus3.IRWrite, bus3.RegWrite,
            bus3.ResultSrc, bus3.ALUSrcA, bus3.ALUSrcB, bus3.ALUControl, bus3.Undef, bus3.ImmSrc, bus3.RegSrc};
  endfunction

  function automatic exp_t obs2();
    return {bus2.State, bus2.PCWrite, bus2.AdrSrc, bus2.MemWrite, bus2.IRWrite, bus2.RegWrite,
            bus2.ResultSrc, bus2.ALUSrcA, bus2.ALUSrcB, 1'b0, bus2.ALUControl, bus2.Undef, bus2.ImmSrc, bus2.RegSrc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ARM condition rule: odd codes invert the even code below them.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    {n, z, cy, v} = f;
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      default: r = !z && (n == v);
    endcase
    return c[0] ? !r : r;
  endfunction

  function automatic exp_t base(input logic [31:0] ins, input logic [3:0] st);
    exp_t e = '0;
    e.st   = st;
    e.imm  = ins[27:26];
    e.rsrc = {ins[27:26] == 2'b01, ins[27:26] == 2'b10};
    return e;
  endfunction

  task automatic push(input exp_t a2, input exp_t a3, input bit mr);
    e2q.push_back(a2); e3q.push_back(a3); mrq.push_back(mr);
  endtask

  // Expected cycle-by-cycle outputs of one instruction, with fetch and
  // memory wait counts; updates the model flags at the end.
  task automatic build(input logic [31:0] ins, input logic [3:0] fl, input int fw, input int mw);
    logic [1:0] op  = ins[27:26];
    logic [3:0] cmd = ins[24:21];
    bit         s   = ins[20];
    bit         r15 = (ins[15:12] == 4'hF);
    exp_t       e, e2;
    int         a3, a2, fm;
    bit         wr3, wr2;
    for (int k = 0; k <= fw; k++) begin
      e = base(ins, 4'd0); e.rs = 2'b10; e.asa = 1'b1; e.asb = 2'b10;
      e.pcw = (k == fw); e.irw = (k == fw);
      push(e, e, k == fw);
    end
    e = base(ins, 4'd1); e.rs = 2'b10; e.asa = 1'b1; e.asb = 2'b10; e.und = (op == 2'b11);
    push(e, e, 1'($urandom));
    if (!cond_holds(ins[31:28], mflags) || op == 2'b11) return;
    if (op == 2'b01) begin
      e = base(ins, 4'd2); e.asb = 2'b01; push(e, e, 1'($urandom));
      if (s) begin
        for (int k = 0; k <= mw; k++) begin
          e = base(ins, 4'd3); e.adr = 1'b1; push(e, e, k == mw);
        end
        e = base(ins, 4'd4); e.rs = 2'b01; e.rw = 1'b1; e.pcw = r15; push(e, e, 1'($urandom));
      end else begin
        for (int k = 0; k <= mw; k++) begin
          e = base(ins, 4'd5); e.adr = 1'b1; e.mw = 1'b1; push(e, e, k == mw);
        end
      end
    end else if (op == 2'b10) begin
      e = base(ins, 4'd9); e.asb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1; push(e, e, 1'($urandom));
    end else begin
      // fm: 0 no flags, 1 NZ only, 2 NZCV
      a2 = 0; wr2 = 1'b0; fm = 0;
      case (cmd)
        4'b0100: begin a2 = 0; wr2 = 1; fm = 2; end
        4'b0010: begin a2 = 1; wr2 = 1; fm = 2; end
        4'b0000: begin a2 = 2; wr2 = 1; fm = 1; end
        4'b1100: begin a2 = 3; wr2 = 1; fm = 2 - 1; end
        4'b1010: begin a2 = 1; wr2 = 0; fm = 2; end
        default: ;
      endcase
      a3 = a2; wr3 = wr2;
      if (cmd == 4'b0001) begin a3 = 4; wr3 = 1; end
      e  = base(ins, ins[25] ? 4'd7 : 4'd6); e.asb = {1'b0, ins[25]};
      e2 = e; e.alu = 3'(a3); e2.alu = 3'(a2);
      push(e2, e, 1'($urandom));
      e  = base(ins, 4'd8); e.rw = wr3; e.pcw = wr3 && r15;
      e2 = base(ins, 4'd8); e2.rw = wr2; e2.pcw = wr2 && r15;
      push(e2, e, 1'($urandom));
      if ((s || cmd == 4'b1010) && fm > 0) begin
        mflags[3:2] = fl[3:2];
        if (fm == 2) mflags[1:0] = fl[1:0];
      end
    end
  endtask

  task automatic run_queue(input logic [31:0] ins, input logic [3:0] fl, input int idx);
    exp_t x2, x3;
    instr_v = ins; alufl_v = fl;
    $display("[TB] rand %0d instr %h cycles %0d", idx, ins, e3q.size());
    while (e3q.size() > 0) begin
      memrdy_v = mrq.pop_front(); x2 = e2q.pop_front(); x3 = e3q.pop_front();
      @(negedge CLK);
      check($sformatf("rand%0d w3 outputs", idx), obs3(), x3);
      check($sformatf("rand%0d w2 outputs", idx), obs2(), x2);
      @(posedge CLK); #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [39:0] seq3 = '0, seq2 = '0;
    logic [2:0]  a3 = '0, a2 = '0;
    int n = 0, rw3 = 0, rw2 = 0, mwc = 0, pcw = 0, und = 0, waited = 0;
    bit done = 1'b0;
    instr_v = v.instr; alufl_v = v.fl;
    while (!done && n < 20) begin
      memrdy_v = 1'b1;
      if ((bus3.State == 4'd3 || bus3.State == 4'd5) && waited < v.mwait) begin
        memrdy_v = 1'b0; waited++;
      end
      @(negedge CLK);
      seq3 = {seq3[35:0], bus3.State}; seq2 = {seq2[35:0], bus2.State}; n++;
      rw3 += int'(bus3.RegWrite); rw2 += int'(bus2.RegWrite);
      mwc += int'(bus3.MemWrite); pcw += int'(bus3.PCWrite); und += int'(bus3.Undef);
      if (bus3.State == 4'd6 || bus3.State == 4'd7) begin
        a3 = bus3.ALUControl; a2 = {1'b0, bus2.ALUControl};
      end
      @(posedge CLK); #1;
      if (bus3.State == 4'd0) done = 1'b1;
    end
    $display("[TB] vec %0d instr %h cycles %0d", idx, v.instr, n);
    check($sformatf("vec%0d finished", idx), done, 1'b1);
    check($sformatf("vec%0d state seq w3", idx), seq3, v.seq);
    check($sformatf("vec%0d state seq w2", idx), seq2, v.seq);
    check($sformatf("vec%0d cycles", idx), n, v.ncyc);
    check($sformatf("vec%0d regwrite w3", idx), rw3, v.rw3);
    check($sformatf("vec%0d regwrite w2", idx), rw2, v.rw2);
    check($sformatf("vec%0d memwrite", idx), mwc, v.mw);
    check($sformatf("vec%0d pcwrite", idx), pcw, v.pcw);
    check($sformatf("vec%0d aluctl w3", idx), a3, v.alu3);
    check($sformatf("vec%0d aluctl w2", idx), a2, v.alu2);
    check($sformatf("vec%0d undef", idx), und, v.und);
  endtask

  initial begin
    //          instr         fl    mw seq            n  rw3 rw2 mw pcw alu3  alu2  und
    tbl[0]  = '{32'hE0821003, 4'hF, 0, 40'h0168,      4, 1, 1, 0, 1, 3'd0, 3'd0, 0}; // ADD, no S
    tbl[1]  = '{32'h00821003, 4'hF, 0, 40'h01,        2, 0, 0, 0, 1, 3'd0, 3'd0, 0}; // ADDEQ, Z=0
    tbl[2]  = '{32'hE2500001, 4'h4, 0, 40'h0178,      4, 1, 1, 0, 1, 3'd1, 3'd1, 0}; // SUBS -> 0100
    tbl[3]  = '{32'h0A000002, 4'h0, 0, 40'h019,       3, 0, 0, 0, 2, 3'd0, 3'd0, 0}; // BEQ taken
    tbl[4]  = '{32'h10821003, 4'h0, 0, 40'h01,        2, 0, 0, 0, 1, 3'd0, 3'd0, 0}; // ADDNE fails
    tbl[5]  = '{32'hE5921004, 4'h0, 3, 40'h01233334,  8, 1, 1, 0, 1, 3'd0, 3'd0, 0}; // LDR, 3 waits
    tbl[6]  = '{32'hE5821004, 4'h0, 2, 40'h012555,    6, 0, 0, 3, 1, 3'd0, 3'd0, 0}; // STR, 2 waits
    tbl[7]  = '{32'hE1510002, 4'h8, 0, 40'h0168,      4, 0, 0, 0, 1, 3'd1, 3'd1, 0}; // CMP -> 1000
    tbl[8]  = '{32'h40821003, 4'h0, 0, 40'h0168,      4, 1, 1, 0, 1, 3'd0, 3'd0, 0}; // ADDMI passes
    tbl[9]  = '{32'hE0210002, 4'h0, 0, 40'h0168,      4, 1, 0, 0, 1, 3'd4, 3'd0, 0}; // EOR
    tbl[10] = '{32'hEC000000, 4'h0, 0, 40'h01,        2, 0, 0, 0, 1, 3'd0, 3'd0, 1}; // Op==11
    tbl[11] = '{32'hE592F004, 4'h0, 0, 40'h01234,     5, 1, 1, 0, 2, 3'd0, 3'd0, 0}; // LDR PC
    tbl[12] = '{32'hE082F003, 4'h0, 0, 40'h0168,      4, 1, 1, 0, 2, 3'd0, 3'd0, 0}; // ADD PC
    tbl[13] = '{32'hE0721003, 4'h4, 0, 40'h0168,      4, 0, 0, 0, 1, 3'd0, 3'd0, 0}; // RSBS unsupported
    tbl[14] = '{32'h00821003, 4'h0, 0, 40'h01,        2, 0, 0, 0, 1, 3'd0, 3'd0, 0}; // ADDEQ still fails
    tbl[15] = '{32'hE0110002, 4'h3, 0, 40'h0168,      4, 1, 1, 0, 1, 3'd2, 3'd2, 0}; // ANDS, CV kept
    tbl[16] = '{32'h20821003, 4'h0, 0, 40'h01,        2, 0, 0, 0, 1, 3'd0, 3'd0, 0}; // ADDCS fails
    tbl[17] = '{32'hEA000000, 4'h0, 0, 40'h019,       3, 0, 0, 0, 2, 3'd0, 3'd0, 0}; // B

    // Reset: write enables forced low even with MemReady high in FETCH.
    RST = 1'b1; instr_v = 32'hE0821003; alufl_v = 4'h0; memrdy_v = 1'b1;
    @(negedge CLK);
    check("reset state w3", bus3.State, 4'd0);
    check("reset state w2", bus2.State, 4'd0);
    check("reset pcwrite", bus3.PCWrite, 1'b0);
    check("reset irwrite", bus3.IRWrite, 1'b0);
    check("reset regwrite+memwrite", {bus3.RegWrite, bus3.MemWrite}, 2'b00);
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

    // Reset asserted in the middle of a MEMWR wait cycle.
    instr_v = 32'hE5821004; memrdy_v = 1'b1;
    for (int k = 0; k < 10 && bus3.State != 4'd5; k++) begin
      @(posedge CLK); #1;
    end
    memrdy_v = 1'b0;
    check("memwr reached", bus3.State, 4'd5);
    #2;
    check("memwr strobe before reset", bus3.MemWrite, 1'b1);
    RST = 1'b1;
    #1;
    check("memwr strobe drops on reset", {bus3.MemWrite, bus2.MemWrite}, 2'b00);
    check("state on async reset w3", bus3.State, 4'd0);
    check("state on async reset w2", bus2.State, 4'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    $display("[TB] seq reset-in-MEMWR done");

    // Random instructions against the reference model (flags cleared by reset).
    mflags = 4'h0;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] r;
      logic [3:0]  fl;
      int          k;
      r = $urandom;
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) r[31:28] = 4'hE;
      if (k < 5) begin
        r[27:26] = 2'b00;
        if (r[24:21] == 4'b0001) r[20] = 1'b0;
      end else if (k < 8) r[27:26] = 2'b01;
      else if (k < 9)     r[27:26] = 2'b10;
      else                r[27:26] = 2'b11;
      fl = 4'($urandom);
      build(r, fl, $urandom_range(0, 2), $urandom_range(0, 3));
      run_queue(r, fl, i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
